// File: rtl/decimal_key_encoder.sv
// rtl/decimal_key_encoder.sv - debounced decimal keypad to BCD encoder with two-digit shift register
module decimal_key_encoder #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       K0,
  input  logic       K1,
  input  logic       K2,
  input  logic       K3,
  input  logic       K4,
  input  logic       K5,
  input  logic       K6,
  input  logic       K7,
  input  logic       K8,
  input  logic       K9,
  input  logic       clr,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic       busy,
  output logic [3:0] TENS,
  output logic [3:0] UNITS
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic [9:0]    w_key_n;
  logic [9:0]    r_sync1;
  logic [9:0]    r_sync2;
  logic [9:0]    w_pressed;
  logic          w_any;
  logic [3:0]    w_code;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nx;
  logic          w_accept;

  logic [3:0]    r_bcd;
  logic          r_valid;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;

  assign w_key_n   = {K9, K8, K7, K6, K5, K4, K3, K2, K1, K0};
  assign w_pressed = ~r_sync2;
  assign w_any     = |w_pressed;

  // Two-flop synchronizer; idle level is released (all ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Priority encode: ascending scan so the highest pressed index wins.
  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_pressed[i]) w_code = 4'(i);
    end
  end

  // FSM state, debounce counter and candidate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
    end
  end

  // Next-state logic: debounce press, wait for release, debounce release.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_cand_nx  = w_code;
          w_cnt_nx   = '0;
          w_state_nx = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!w_any || (w_code != r_cand)) begin
          w_state_nx = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nx = HELD;
          w_accept   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_any) begin
          w_cnt_nx   = '0;
          w_state_nx = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (w_any) begin
          w_state_nx = HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Accept strobe, BCD latch and the TENS/UNITS shift with clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bcd   <= 4'd0;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_bcd   <= r_cand;
        r_tens  <= clr ? 4'd0 : r_units;
        r_units <= r_cand;
      end else if (clr) begin
        r_tens  <= 4'd0;
        r_units <= 4'd0;
      end
    end
  end

  assign {D, C, B, A} = r_bcd;
  assign valid        = r_valid;
  assign busy         = (r_state != IDLE);
  assign TENS         = r_tens;
  assign UNITS        = r_units;

endmodule
